// File: rtl/imm_inst_encoder.sv
// Packs register fields, funct3 and a 12-bit immediate into an I/S/SB word
// and streams it little-endian, a byte per cycle, into instruction memory.
module imm_inst_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter logic [63:0] MEM_BYTES = 64'd256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_restart,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [63:0] i_imm,
    output logic [31:0] o_inst_out,
    output logic        o_mem_we,
    output logic [63:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic [63:0] o_wr_ptr,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WR0,
        S_WR1,
        S_WR2,
        S_WR3,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [63:0] r_imm;

    logic [11:0] w_i;
    logic [1:0]  w_fmt;
    logic [31:0] w_inst;
    logic        w_imm_ok;
    logic        w_fmt_bad;
    logic        w_full;
    logic        w_reject;
    logic [63:0] w_ptr_next;
    logic [63:0] w_limit;

    assign w_i        = r_imm[11:0];
    assign w_fmt      = r_opcode[6:5];
    assign w_imm_ok   = (&r_imm[63:11]) | ~(|r_imm[63:11]);
    assign w_fmt_bad  = (w_fmt == 2'b10);
    assign w_ptr_next = o_wr_ptr + 64'd4;
    assign w_limit    = BASE_ADDR + MEM_BYTES;
    assign w_full     = (w_ptr_next > w_limit);
    assign w_reject   = ~w_imm_ok | w_fmt_bad | w_full;

    // SB scatters the immediate the same way the decoder gathers it back
    always_comb begin
        w_inst = 32'd0;
        unique case (w_fmt)
            2'b01: begin
                w_inst = {w_i[11:5], r_rs2, r_rs1, r_funct3,
                          w_i[4:0], r_opcode};
            end
            2'b11: begin
                w_inst = {w_i[11], w_i[9:4], r_rs2, r_rs1, r_funct3,
                          w_i[3:0], w_i[10], r_opcode};
            end
            default: begin
                w_inst = {w_i, r_rs1, r_funct3, r_rd, r_opcode};
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_opcode    <= 7'd0;
            r_rd        <= 5'd0;
            r_funct3    <= 3'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_imm       <= 64'd0;
            o_req_ready <= 1'b1;
            o_inst_out  <= 32'd0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 64'd0;
            o_mem_wdata <= 8'd0;
            o_wr_ptr    <= BASE_ADDR;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_mem_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_restart) begin
                        o_wr_ptr <= BASE_ADDR;
                    end
                    if (i_req_valid) begin
                        r_opcode    <= i_opcode;
                        r_rd        <= i_rd;
                        r_funct3    <= i_funct3;
                        r_rs1       <= i_rs1;
                        r_rs2       <= i_rs2;
                        r_imm       <= i_imm;
                        o_req_ready <= 1'b0;
                        r_state     <= S_ENC;
                    end
                end
                S_ENC: begin
                    o_inst_out <= w_inst;
                    if (w_reject) begin
                        o_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= o_wr_ptr;
                        o_mem_wdata <= w_inst[7:0];
                        r_state     <= S_WR0;
                    end
                end
                S_WR0: begin
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= o_wr_ptr + 64'd1;
                    o_mem_wdata <= o_inst_out[15:8];
                    r_state     <= S_WR1;
                end
                S_WR1: begin
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= o_wr_ptr + 64'd2;
                    o_mem_wdata <= o_inst_out[23:16];
                    r_state     <= S_WR2;
                end
                S_WR2: begin
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= o_wr_ptr + 64'd3;
                    o_mem_wdata <= o_inst_out[31:24];
                    r_state     <= S_WR3;
                end
                S_WR3: begin
                    o_done   <= 1'b1;
                    o_wr_ptr <= w_ptr_next;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    o_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ERR: begin
                    o_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    o_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Directed bench for imm_inst_encoder: encodings, byte stream timing,
// error/full rejection, restart and mid-write reset.
module tb_imm_inst_encoder;

    logic        clk;
    logic        rst;
    logic        restart_a;
    logic        restart_b;
    logic        rv_a;
    logic        rv_b;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;

    logic        rdy_a, we_a, done_a, err_a;
    logic        rdy_b, we_b, done_b, err_b;
    logic [31:0] inst_a, inst_b;
    logic [63:0] addr_a, addr_b, ptr_a, ptr_b;
    logic [7:0]  wd_a, wd_b;

    logic        sel;
    logic        s_rdy, s_we, s_done, s_err;
    logic [31:0] s_inst;
    logic [63:0] s_addr, s_ptr;
    logic [7:0]  s_wd;

    int          n_chk;
    int          n_err;
    logic [63:0] mp [2];
    logic [63:0] base [2];

    imm_inst_encoder #(.BASE_ADDR(64'd0), .MEM_BYTES(64'd256)) u_a (
        .i_clk(clk), .i_reset(rst), .i_restart(restart_a),
        .i_req_valid(rv_a), .o_req_ready(rdy_a), .i_opcode(opcode),
        .i_rd(rd), .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2),
        .i_imm(imm), .o_inst_out(inst_a), .o_mem_we(we_a),
        .o_mem_addr(addr_a), .o_mem_wdata(wd_a), .o_wr_ptr(ptr_a),
        .o_done(done_a), .o_err(err_a)
    );

    imm_inst_encoder #(.BASE_ADDR(64'h100), .MEM_BYTES(64'd8)) u_b (
        .i_clk(clk), .i_reset(rst), .i_restart(restart_b),
        .i_req_valid(rv_b), .o_req_ready(rdy_b), .i_opcode(opcode),
        .i_rd(rd), .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2),
        .i_imm(imm), .o_inst_out(inst_b), .o_mem_we(we_b),
        .o_mem_addr(addr_b), .o_mem_wdata(wd_b), .o_wr_ptr(ptr_b),
        .o_done(done_b), .o_err(err_b)
    );

    assign s_rdy  = sel ? rdy_b  : rdy_a;
    assign s_we   = sel ? we_b   : we_a;
    assign s_done = sel ? done_b : done_a;
    assign s_err  = sel ? err_b  : err_a;
    assign s_inst = sel ? inst_b : inst_a;
    assign s_addr = sel ? addr_b : addr_a;
    assign s_ptr  = sel ? ptr_b  : ptr_a;
    assign s_wd   = sel ? wd_b   : wd_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dec_sb(input logic [31:0] w);
        logic [11:0] x;
        x = {w[31], w[7], w[30:25], w[11:8]};
        return {{52{x[11]}}, x};
    endfunction

    task automatic do_req(input bit b, input logic [6:0] op,
                          input logic [4:0] f_rd, input logic [2:0] f3,
                          input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                          input logic [63:0] f_imm, input bit rs_same,
                          input bit exp_err, input bit chk_inst,
                          input logic [31:0] w, input string tag);
        logic [63:0] p;
        sel = b;
        @(negedge clk);
        opcode = op; rd = f_rd; funct3 = f3;
        rs1 = f_rs1; rs2 = f_rs2; imm = f_imm;
        if (b) begin
            rv_b = 1'b1;
            restart_b = rs_same;
        end else begin
            rv_a = 1'b1;
        end
        if (rs_same) mp[b] = base[b];
        p = mp[b];
        chk({tag, ":rdy"}, s_rdy, 1);
        @(posedge clk); #1;
        rv_a = 1'b0; rv_b = 1'b0; restart_b = 1'b0;
        chk({tag, ":enc_we"}, s_we, 0);
        chk({tag, ":busy"}, s_rdy, 0);
        if (exp_err) begin
            @(posedge clk); #1;
            chk({tag, ":err"}, s_err, 1);
            chk({tag, ":err_we"}, s_we, 0);
            chk({tag, ":err_ptr"}, s_ptr, p);
            @(posedge clk); #1;
            chk({tag, ":err_rdy"}, s_rdy, 1);
            chk({tag, ":err_low"}, s_err, 0);
            chk({tag, ":err_ptr2"}, s_ptr, p);
        end else begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                chk({tag, ":we"}, s_we, 1);
                chk({tag, ":addr"}, s_addr, p + 64'(k));
                chk({tag, ":byte"}, s_wd, w[8*k +: 8]);
            end
            @(posedge clk); #1;
            chk({tag, ":done"}, s_done, 1);
            chk({tag, ":done_we"}, s_we, 0);
            @(posedge clk); #1;
            chk({tag, ":rdy_again"}, s_rdy, 1);
            chk({tag, ":done_low"}, s_done, 0);
            chk({tag, ":ptr"}, s_ptr, p + 64'd4);
            mp[b] = p + 64'd4;
        end
        if (chk_inst) chk({tag, ":inst"}, s_inst, w);
    endtask

    initial begin
        int acc;
        int dn;
        n_chk = 0; n_err = 0;
        base[0] = 64'd0; base[1] = 64'h100;
        mp[0] = base[0]; mp[1] = base[1];
        sel = 1'b0;
        rst = 1'b1; restart_a = 1'b0; restart_b = 1'b0;
        rv_a = 1'b0; rv_b = 1'b0;
        opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", rdy_a, 1);
        chk("rst_inst", inst_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wd_a, 0);
        chk("rst_ptr", ptr_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_ptr_b", ptr_b, 64'h100);
        @(negedge clk); rst = 1'b0;

        do_req(0, 7'b0010011, 5, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
               0, 0, 1, 32'hFFF00293, "itype");
        do_req(0, 7'b0100011, 0, 3, 2, 6, 64'd8,
               0, 0, 1, 32'h00613423, "stype");
        do_req(0, 7'b1100011, 0, 0, 1, 2, 64'd4,
               0, 0, 1, 32'h00208463, "sbtype");
        chk("sb_decode", dec_sb(inst_a), 64'd4);
        do_req(0, 7'b0010011, 0, 0, 0, 0, 64'd2048,
               0, 1, 1, 32'h80000013, "imm_hi");
        do_req(0, 7'b0010011, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_F7FF,
               0, 1, 1, 32'h7FF08093, "imm_lo");
        do_req(0, 7'b1010011, 0, 0, 0, 0, 64'd0,
               0, 1, 0, 32'd0, "fmt");

        do_req(1, 7'b0010011, 5, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
               0, 0, 1, 32'hFFF00293, "full1");
        do_req(1, 7'b0100011, 0, 3, 2, 6, 64'd8,
               0, 0, 1, 32'h00613423, "full2");
        do_req(1, 7'b1100011, 0, 0, 1, 2, 64'd4,
               0, 1, 0, 32'd0, "full3");
        chk("full_ptr", ptr_b, 64'h108);
        sel = 1'b1;
        @(negedge clk); restart_b = 1'b1;
        @(posedge clk); #1; restart_b = 1'b0;
        mp[1] = base[1];
        chk("restart_ptr", ptr_b, 64'h100);
        do_req(1, 7'b1100011, 0, 0, 1, 2, 64'd4,
               0, 0, 1, 32'h00208463, "after_rst");
        do_req(1, 7'b0010011, 5, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
               1, 0, 1, 32'hFFF00293, "rst_same");

        sel = 1'b0;
        @(negedge clk);
        opcode = 7'b0010011; rd = 5; funct3 = 0; rs1 = 0; rs2 = 0;
        imm = 64'hFFFF_FFFF_FFFF_FFFF;
        rv_a = 1'b1;
        @(posedge clk); #1; rv_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_wr2_we", we_a, 1);
        chk("mid_wr2_addr", addr_a, mp[0] + 64'd2);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rdy", rdy_a, 1);
        chk("mid_we", we_a, 0);
        chk("mid_ptr", ptr_a, 0);
        chk("mid_done", done_a, 0);
        mp[0] = base[0]; mp[1] = base[1];
        @(negedge clk); rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        chk("mid_no_done", dn, 0);

        acc = 0; dn = 0;
        @(negedge clk);
        rv_a = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            if (rv_a && rdy_a) acc++;
            if (done_a) dn++;
        end
        rv_a = 1'b0;
        @(negedge clk);
        chk("b2b_accepts", acc, 3);
        chk("b2b_dones", dn, 3);
        chk("b2b_rdy", rdy_a, 1);
        chk("b2b_ptr", ptr_a, mp[0] + 64'd12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
